// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and types for the register-file dump reader.
package reg_dump_reader_pkg;

  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned NUM_ARCH_REGS = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } dump_state_e;

  // One output beat as held in the output register.
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] index;
    logic                  last;
  } dump_beat_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks a register file through a combinational read port and streams each
// entry out as a valid/ready beat, ending with a one-cycle done pulse.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter bit          SKIP_ZERO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [REG_ADDR_W-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = SKIP_ZERO ? REG_ADDR_W'(1) : REG_ADDR_W'(0);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(NUM_REGS - 1);

  dump_state_e           state_q, state_d;
  logic [REG_ADDR_W-1:0] idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic                  valid_q, valid_d;
  dump_beat_t            beat_q, beat_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  hs_c;
  logic                  load_c;

  // Handshake on the current beat, and a load whenever a fetch is pending
  // and the output register is empty or being drained this cycle.
  assign hs_c   = valid_q && out_ready;
  assign load_c = (state_q == STREAM) && pend_q && (!valid_q || out_ready);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over a same-cycle handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hs_c && beat_q.last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fetch counter and output register next values.
  always_comb begin
    idx_d   = idx_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          idx_d  = FIRST_IDX;
          pend_d = 1'b1;
        end
      end
      STREAM: begin
        if (abort) begin
          valid_d = 1'b0;
          pend_d  = 1'b0;
          idx_d   = '0;
        end else begin
          if (hs_c) begin
            valid_d = 1'b0;
          end
          if (load_c) begin
            beat_d.data  = rd_data;
            beat_d.index = idx_q;
            beat_d.last  = (idx_q == LAST_IDX);
            valid_d      = 1'b1;
            // Saturate at the last entry instead of wrapping.
            if (idx_q == LAST_IDX) begin
              pend_d = 1'b0;
            end else begin
              idx_d = idx_q + REG_ADDR_W'(1);
            end
          end
        end
      end
      DONE: begin
        valid_d = 1'b0;
        pend_d  = 1'b0;
        idx_d   = '0;
      end
      default: begin
        valid_d = 1'b0;
        pend_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Read address follows the pending fetch; parked at 0 while idle.
  assign rd_addr = (state_q == IDLE) ? '0 : idx_q;

  assign out_valid = valid_q;
  assign out_data  = beat_q.data;
  assign out_index = beat_q.index;
  assign out_last  = beat_q.last;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: one instance with SKIP_ZERO=0 and
// one with SKIP_ZERO=1, both reading a bench-owned register array.
module tb_reg_dump_reader;
  import reg_dump_reader_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, abort0, ready0, start1, abort1, ready1;
  logic [4:0]  rd_addr0, rd_addr1, out_index0, out_index1;
  logic [31:0] rd_data0, rd_data1, out_data0, out_data1;
  logic        out_valid0, out_last0, busy0, done0;
  logic        out_valid1, out_last1, busy1, done1;

  logic [31:0] regs [32];

  always #5 clk = ~clk;

  assign rd_data0 = regs[rd_addr0];
  assign rd_data1 = regs[rd_addr1];

  reg_dump_reader #(.NUM_REGS(32), .SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .out_valid(out_valid0),
    .out_ready(ready0), .out_data(out_data0), .out_index(out_index0),
    .out_last(out_last0), .busy(busy0), .done(done0)
  );

  reg_dump_reader #(.NUM_REGS(32), .SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(out_valid1),
    .out_ready(ready1), .out_data(out_data1), .out_index(out_index1),
    .out_last(out_last1), .busy(busy1), .done(done1)
  );

  int    tests = 0;
  int    fails = 0;
  beat_t exp0[$];
  beat_t exp1[$];
  int    hs_cnt0 = 0, hs_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;
  time   first_hs_t0 = 0, last_hs_t0 = 0;
  logic  stall0 = 1'b0, prev_abort0 = 1'b0;
  beat_t held0, e0, e1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Expected beat for entry i of the pattern regs[i] = i * 0x01010101.
  function automatic beat_t pat(input int i);
    beat_t b;
    b.data = 32'(i) * 32'h0101_0101;
    b.idx  = 5'(i);
    b.last = (i == 31);
    return b;
  endfunction

  task automatic push0(input int first, input int last_incl);
    for (int i = first; i <= last_incl; i++) exp0.push_back(pat(i));
  endtask

  task automatic push1(input int first, input int last_incl);
    for (int i = first; i <= last_incl; i++) exp1.push_back(pat(i));
  endtask

  // Scoreboard and stall-stability monitor for the SKIP_ZERO=0 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall0      = 1'b0;
      prev_abort0 = 1'b0;
    end else begin
      if (stall0 && !prev_abort0) begin
        chk("stall_valid0", 32'(out_valid0), 32'd1);
        chk("stall_data0",  out_data0, held0.data);
        chk("stall_index0", 32'(out_index0), 32'(held0.idx));
        chk("stall_last0",  32'(out_last0), 32'(held0.last));
      end
      if (out_valid0 && ready0) begin
        if (exp0.size() == 0) begin
          timeout_fail("unexpected_beat0");
        end else begin
          e0 = exp0.pop_front();
          chk("beat_data0",  out_data0, e0.data);
          chk("beat_index0", 32'(out_index0), 32'(e0.idx));
          chk("beat_last0",  32'(out_last0), 32'(e0.last));
        end
        if (hs_cnt0 == 0) first_hs_t0 = $time;
        last_hs_t0 = $time;
        hs_cnt0++;
      end
      stall0      = out_valid0 && !ready0;
      held0.data  = out_data0;
      held0.idx   = out_index0;
      held0.last  = out_last0;
      prev_abort0 = abort0;
      if (done0) done_cnt0++;
    end
  end

  // Scoreboard for the SKIP_ZERO=1 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid1 && ready1) begin
        if (exp1.size() == 0) begin
          timeout_fail("unexpected_beat1");
        end else begin
          e1 = exp1.pop_front();
          chk("beat_data1",  out_data1, e1.data);
          chk("beat_index1", 32'(out_index1), 32'(e1.idx));
          chk("beat_last1",  32'(out_last1), 32'(e1.last));
        end
        hs_cnt1++;
      end
      if (done1) done_cnt1++;
    end
  end

  // Pulse start0 for one cycle; reports the first negedge after the start edge.
  task automatic start_dump0(output time t_s);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    t_s = $time;
    chk("start_busy0",  32'(busy0), 32'd1);
    chk("start_valid0", 32'(out_valid0), 32'd0);
  endtask

  task automatic wait_done(input bit which, input int bound, output time t_d);
    bit got = 1'b0;
    t_d = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (which ? done1 : done0) begin
        got = 1'b1;
        t_d = $time;
        break;
      end
    end
    if (!got) timeout_fail(which ? "wait_done1" : "wait_done0");
  endtask

  task automatic wait_index0(input int idx, input int bound);
    bit got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (out_valid0 && out_index0 == 5'(idx)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout_fail("wait_index0");
  endtask

  task automatic init_regs();
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_s, t_d;
    int  dc;
    rst_n  = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b0;
    init_regs();

    // Reset state.
    #12;
    chk("rst_valid", 32'(out_valid0), 32'd0);
    chk("rst_data",  out_data0, 32'd0);
    chk("rst_index", 32'(out_index0), 32'd0);
    chk("rst_last",  32'(out_last0), 32'd0);
    chk("rst_busy",  32'(busy0), 32'd0);
    chk("rst_done",  32'(done0), 32'd0);
    chk("rst_addr",  32'(rd_addr0), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Full-rate dump with out_ready held high.
    ready0 = 1'b1;
    hs_cnt0 = 0;
    push0(0, 31);
    start_dump0(t_s);
    wait_done(1'b0, 100, t_d);
    chk("t1_latency", 32'(first_hs_t0 - t_s), 32'd10);
    chk("t1_span",    32'(last_hs_t0 - first_hs_t0), 32'd310);
    chk("t1_beats",   32'(hs_cnt0), 32'd32);
    chk("t1_done_at", 32'(t_d - last_hs_t0), 32'd10);
    @(negedge clk);
    chk("t1_done_width", 32'(done0), 32'd0);
    chk("t1_idle_busy",  32'(busy0), 32'd0);
    chk("t1_queue", 32'(exp0.size()), 32'd0);

    // Alternating out_ready.
    hs_cnt0 = 0;
    dc = done_cnt0;
    push0(0, 31);
    start_dump0(t_s);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (done0) begin got = 1'b1; break; end
        @(posedge clk); #1 ready0 = !ready0;
      end
      if (!got) timeout_fail("t2_done");
    end
    @(negedge clk);
    chk("t2_beats", 32'(hs_cnt0), 32'd32);
    chk("t2_done_cnt", 32'(done_cnt0 - dc), 32'd1);
    chk("t2_queue", 32'(exp0.size()), 32'd0);

    // SKIP_ZERO instance: 31 beats starting at index 1.
    ready1 = 1'b1;
    push1(1, 31);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_done(1'b1, 100, t_d);
    @(negedge clk);
    chk("t3_beats", 32'(hs_cnt1), 32'd31);
    chk("t3_done_cnt", 32'(done_cnt1), 32'd1);
    chk("t3_queue", 32'(exp1.size()), 32'd0);
    chk("t3_busy", 32'(busy1), 32'd0);

    // Abort while beat 10 waits, then restart from index 0.
    ready0 = 1'b1;
    hs_cnt0 = 0;
    dc = done_cnt0;
    push0(0, 9);
    start_dump0(t_s);
    wait_index0(9, 100);
    @(posedge clk); #1 ready0 = 1'b0; abort0 = 1'b1;
    @(negedge clk);
    chk("t4_wait_valid", 32'(out_valid0), 32'd1);
    chk("t4_wait_index", 32'(out_index0), 32'd10);
    @(posedge clk); #1 abort0 = 1'b0;
    @(negedge clk);
    chk("t4_abort_valid", 32'(out_valid0), 32'd0);
    chk("t4_abort_busy",  32'(busy0), 32'd0);
    chk("t4_abort_done",  32'(done0), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_no_done", 32'(done_cnt0 - dc), 32'd0);
    chk("t4_beats", 32'(hs_cnt0), 32'd10);
    ready0 = 1'b1;
    hs_cnt0 = 0;
    push0(0, 31);
    start_dump0(t_s);
    wait_done(1'b0, 100, t_d);
    @(negedge clk);
    chk("t4_restart_beats", 32'(hs_cnt0), 32'd32);
    chk("t4_queue", 32'(exp0.size()), 32'd0);

    // Ignored mid-dump start, then asynchronous reset at beat 5.
    hs_cnt0 = 0;
    dc = done_cnt0;
    push0(0, 4);
    start_dump0(t_s);
    wait_index0(2, 100);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    wait_index0(4, 100);
    @(posedge clk); #1 ready0 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid0), 32'd0);
    chk("t5_rst_busy",  32'(busy0), 32'd0);
    chk("t5_rst_done",  32'(done0), 32'd0);
    @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_no_done", 32'(done_cnt0 - dc), 32'd0);
    chk("t5_idle", 32'(busy0), 32'd0);
    chk("t5_beats", 32'(hs_cnt0), 32'd5);
    chk("t5_queue", 32'(exp0.size()), 32'd0);

    // Register 20 rewritten mid-dump before its beat loads.
    ready0 = 1'b1;
    hs_cnt0 = 0;
    push0(0, 19);
    exp0.push_back('{data: 32'hDEAD_BEEF, idx: 5'd20, last: 1'b0});
    push0(21, 31);
    start_dump0(t_s);
    wait_index0(5, 100);
    regs[20] = 32'hDEAD_BEEF;
    wait_done(1'b0, 100, t_d);
    @(negedge clk);
    chk("t6_beats", 32'(hs_cnt0), 32'd32);
    chk("t6_queue", 32'(exp0.size()), 32'd0);
    init_regs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, meaning the number of register-file entries walked per dump (2..32).
REQ-002 SHALL have parameter SKIP_ZERO, default 0, meaning that when 1 the dump starts at index 1 and emits NUM_REGS-1 beats.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  dump request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of an active dump.
REQ-007 SHALL have port rd_addr  output  5  address driven to a register-file read port.
REQ-008 SHALL have port rd_data  input  32  combinational read data for rd_addr, valid in the same cycle.
REQ-009 SHALL have port out_valid  output  1  out_data/out_index/out_last hold a beat.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the beat.
REQ-011 SHALL have port out_data  output  32  register contents.
REQ-012 SHALL have port out_index  output  5  register number of out_data.
REQ-013 SHALL have port out_last  output  1  final beat of the dump.
REQ-014 SHALL have port busy  output  1  a dump is in progress.
REQ-015 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, STREAM and DONE.
REQ-017 SHALL take IDLE->STREAM on an edge where start=1, setting the fetch index to SKIP_ZERO?1:0.
REQ-018 SHALL capture rd_data into out_data on a load edge, with out_index = the fetch index and out_valid=1, where a load edge is one in STREAM with a fetch pending and (out_valid=0 or out_ready=1).
REQ-019 SHALL drive rd_addr combinationally to the pending fetch index at all times, and to 0 in IDLE.
REQ-020 SHALL present the first beat on the edge after the start edge, i.e. a latency of 1 cycle.
REQ-021 SHALL sustain 1 beat per cycle while out_ready=1 by loading the next beat on the same edge that the current beat handshakes.
REQ-022 SHALL hold out_data, out_index and out_last stable while out_valid=1 and out_ready=0, and SHALL NOT deassert out_valid before the handshake.
REQ-023 SHALL assert out_last only with the beat at index NUM_REGS-1.
REQ-024 SHALL enter DONE on the edge where the last beat handshakes, with out_valid going to 0.
REQ-025 SHALL make DONE last exactly 1 cycle with done=1, then return to IDLE.
REQ-026 SHALL hold busy=1 exactly in the states STREAM and DONE.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL, on abort=1 in STREAM, go to IDLE on the next edge with out_valid=0 and no done pulse.
REQ-029 SHALL give abort priority over a simultaneous handshake.
REQ-030 SHALL ignore abort in IDLE and DONE.
REQ-031 SHALL compute the fetch index with 5-bit width and never wrap past NUM_REGS-1.
REQ-032 SHALL place no constraint on concurrent register-file writes; each beat reflects the register contents at its load edge.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force state IDLE, fetch index 0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0 and done=0.
REQ-034 SHALL discard a dump interrupted by reset, with no partial completion and no done pulse.
REQ-035 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-036 SHALL take the FSM state enum, REG_ADDR_W=5 and DATA_W=32 from the shared processor package, alongside the register-file constants.
REQ-037 SHALL be a single module with no sub-module; the fetch counter and output register are inline.

Verification
REQ-038 SHALL test: regs[i]=i*0x01010101, out_ready=1, start pulse -> 32 beats on consecutive cycles, index 0..31, out_last on index 31, done high for 1 cycle immediately after.
REQ-039 SHALL test: out_ready alternating 1/0 -> 32 beats, no drops or duplicates, and out_data constant across every stalled cycle.
REQ-040 SHALL test: SKIP_ZERO=1 -> 31 beats, index 1..31, the first beat out_data=0x01010101.
REQ-041 SHALL test: abort while beat 10 is waiting -> out_valid=0 and busy=0 on the next edge with no done; a subsequent start restarts at index 0.
REQ-042 SHALL test: rst_n driven low between edges at beat 5 -> out_valid/busy are 0 immediately; a start pulse applied mid-dump is ignored.
REQ-043 SHALL test: reg 20 written with 0xDEADBEEF during the dump, before beat 20 loads -> beat 20 out_data=0xDEADBEEF.
